// File: rtl/encoder_event_fifo.sv
// Edge-detecting event FIFO behind a 4x2 priority encoder: new (y,z) requests are queued as indices.
// Optional ENC_FIFO_DROPCNT_EN adds a saturating 4-bit drop counter output (drop_cnt).
module encoder_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             z,
  input  logic                   y,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [1:0]             idx,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef ENC_FIFO_DROPCNT_EN
  ,
  output logic [3:0]             drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]    y_q_z;
  logic          y_q;
  logic [1:0]    z_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    mem [DEPTH];
  logic          evt, pop, push, drop;

  assign y_q_z = z_q;
  // A held, unchanged request is one event, not one per cycle
  assign evt   = y && (!y_q || (z != y_q_z));
  assign valid = (count != '0);
  assign full  = (count == DEPTH_C);
  assign pop   = rd_en && valid;
  // When full, a same-edge pop frees the slot the push lands in
  assign push  = evt && (!full || pop);
  assign drop  = evt && full && !pop;
  assign idx   = valid ? mem[rd_ptr] : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= 1'b0;
      z_q      <= 2'b00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      y_q <= y;
      z_q <= z;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage needs no reset; idx is masked by valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= z;
  end

`ifdef ENC_FIFO_DROPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= 4'd0;
    else if (clr_ovf)                  drop_cnt <= drop ? 4'd1 : 4'd0;
    else if (drop && drop_cnt != 4'hf) drop_cnt <= drop_cnt + 4'd1;
  end
`endif
endmodule

// File: doc/encoder_event_fifo.md
ENCODER_EVENT_FIFO -- requirements
Module: encoder_event_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 z  input  2  encoded index from the 4x2 priority encoder.
REQ-005 y  input  1  encoder control/valid; 1 = at least one input asserted.
REQ-006 rd_en  input  1  consumer pop request for the head entry.
REQ-007 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 idx  output  2  head-of-FIFO index (first-word-fall-through).
REQ-009 valid  output  1  1 when the FIFO holds at least one entry.
REQ-010 full  output  1  1 when the FIFO holds DEPTH entries.
REQ-011 count  output  $clog2(DEPTH)+1  current entry count.
REQ-012 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 The block SHALL register y and z every cycle as y_q, z_q (reset 0, 2'b00).
REQ-014 An event SHALL be detected in a cycle when y=1 and (y_q=0 or z!=z_q); a held, unchanged request SHALL NOT generate repeat events.
REQ-015 A detected event SHALL push z into the FIFO at the rising edge closing that cycle; it appears on idx/valid in the following cycle when the FIFO was empty (1-cycle latency).
REQ-016 y=0 SHALL never push, whatever the value of z.
REQ-017 A pop SHALL occur at a clock edge when rd_en=1 and valid=1; rd_en while valid=0 SHALL be ignored, with no state change.
REQ-018 idx SHALL present the oldest entry; when valid=0, idx SHALL be 2'b00.
REQ-019 Entries SHALL leave in arrival order; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when full (push accepted because a slot frees) and when count=1.
REQ-021 A push while full and not popping SHALL be dropped; FIFO contents and count are unchanged; overflow SHALL be set at that edge.
REQ-022 overflow SHALL remain 1 until a clock edge with clr_ovf=1; if clr_ovf and a new drop coincide, overflow SHALL be 1 (set wins).
REQ-023 valid = (count!=0); full = (count==DEPTH); both SHALL be derived from registered count with no combinational path from inputs.

Reset
REQ-024 While rst_n=0: count=0, pointers=0, y_q=0, z_q=0, overflow=0; hence valid=0, full=0, idx=2'b00.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries immediately; the first edge after release with y=1 SHALL count as a new event.

Configuration
REQ-026 Macro ENC_FIFO_DROPCNT_EN: when defined, the block SHALL add output drop_cnt (4 bits), reset 0, incremented on every dropped push, saturating at 15, cleared with overflow by clr_ovf (clear-then-increment on a coinciding drop gives 1).
REQ-027 Without ENC_FIFO_DROPCNT_EN, drop_cnt SHALL NOT exist; all other behaviour is identical.

Verification
REQ-028 Reset, then y=1 with z=2'b11 held for 5 cycles -> exactly one entry; idx=11, count=1, valid=1 one cycle after the first edge.
REQ-029 Sequence (y,z) = (1,00),(1,01),(0,xx),(1,01) over 4 cycles, no reads -> count=3, pops return 00,01,01 in order, then valid=0.
REQ-030 Fill to DEPTH=4 with distinct events, issue a fifth event with rd_en=0 -> count stays 4, full=1, overflow=1, contents unchanged; clr_ovf pulse -> overflow=0.
REQ-031 Full FIFO, new event with rd_en=1 on the same edge -> count stays 4, oldest entry removed, new index at tail.
REQ-032 Store 3 entries, assert rst_n=0 between edges -> valid=0 and count=0 immediately; after release, held y=1 z=10 -> one new entry 10.
REQ-033 With ENC_FIFO_DROPCNT_EN, 17 drops while full -> drop_cnt=15; clr_ovf plus a coinciding drop -> drop_cnt=1, overflow=1.
